cam_alloc_ctrl: RTL and testbench
=================================

CAM_ALLOC_CTRL -- requirements
Module: cam_alloc_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: key width; equals the CAM's search width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: log2 of the CAM entry count.
REQ-003 SHALL have ports: clk  in  1  sole clock; rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: req_valid in 1; req_ready out 1; req_op in 1 (0=insert, 1=delete); req_data in DATA_WIDTH (key).
REQ-005 SHALL have ports: resp_valid out 1 (one-cycle pulse); resp_status out 2 (OK, FULL, DUP, NOTFOUND); resp_addr out ADDR_WIDTH.
REQ-006 SHALL have CAM write-side ports: cam_write_addr out ADDR_WIDTH; cam_write_data out DATA_WIDTH; cam_write_delete out 1; cam_write_enable out 1; cam_write_busy in 1.
REQ-007 SHALL have CAM compare-side ports: cam_compare_data out DATA_WIDTH; cam_match in 1; cam_match_addr in ADDR_WIDTH.
REQ-008 SHALL have status ports: free_count out ADDR_WIDTH+1; full out 1 (free_count==0).

Function
REQ-009 SHALL keep a valid bitmap of 2**ADDR_WIDTH bits and a free counter; allocation picks the lowest-index clear bit.
REQ-010 SHALL use states IDLE, LOOKUP_1, LOOKUP_2, ISSUE, WAIT, RESP.
REQ-011 req_ready SHALL be high only in IDLE with cam_write_busy low; a request is accepted on req_valid&&req_ready, latching op and key.
REQ-012 IDLE->LOOKUP_1 on acceptance; cam_compare_data SHALL hold the latched key from LOOKUP_1 through RESP.
REQ-013 LOOKUP_1->LOOKUP_2 unconditionally (CAM match has one-cycle read latency); cam_match/cam_match_addr SHALL be sampled in LOOKUP_2.
REQ-014 Delete: LOOKUP_2 with cam_match=0 -> RESP with NOTFOUND and no CAM write; with cam_match=1 -> ISSUE targeting cam_match_addr, cam_write_delete=1.
REQ-015 Insert: LOOKUP_2 with cam_match=1 -> RESP with DUP and resp_addr=cam_match_addr; else full -> RESP with FULL; else ISSUE targeting the allocated lowest free index, cam_write_delete=0.
REQ-016 ISSUE SHALL assert cam_write_enable for exactly one cycle, only when cam_write_busy is low (else hold in ISSUE), then go to WAIT.
REQ-017 WAIT SHALL remain at least one cycle and exit to RESP on the first cycle with cam_write_busy low after that.
REQ-018 Bitmap and free_count SHALL update in the ISSUE cycle where cam_write_enable asserts (insert: set bit, count-1; delete: clear bit, count+1).
REQ-019 RESP SHALL pulse resp_valid for one cycle with status and address, then return to IDLE; back-to-back requests are accepted from the following cycle.
REQ-020 Insert latency with no busy stall SHALL be accept + 5 cycles to resp_valid; a rejected request (DUP/FULL/NOTFOUND) SHALL take accept + 3 cycles.
REQ-021 free_count SHALL never underflow or exceed 2**ADDR_WIDTH; insert when full SHALL be rejected, never issued.

Reset
REQ-022 While rst is low: state=IDLE, bitmap cleared, free_count=2**ADDR_WIDTH, full=0, req_ready=0, resp_valid=0, cam_write_enable=0, all other outputs 0.
REQ-023 Reset mid-operation SHALL abandon the request without a response; the CAM is reset in the same domain, so the two stay coherent.
REQ-024 After release, req_ready SHALL stay low until cam_write_busy (CAM init) deasserts.

Configuration
REQ-025 Macro CAM_ALLOC_DUP_CHECK_EN: when defined, inserts follow REQ-015.
REQ-026 When CAM_ALLOC_DUP_CHECK_EN is undefined, insert SHALL skip LOOKUP_1/LOOKUP_2 (IDLE->ISSUE, or RESP FULL if full) and DUP SHALL never be reported; no-stall insert latency becomes accept + 3 cycles; delete is unchanged.

Structure
REQ-027 Op codes (OP_INSERT, OP_DELETE) and status codes (ST_OK=0, ST_FULL=1, ST_DUP=2, ST_NOTFOUND=3) SHALL live in shared package cam_pkg.
REQ-028 The free-slot search SHALL instantiate the existing priority_encoder (LSB priority) on the inverted bitmap; no other sub-module.

Verification
REQ-029 Reset, CAM busy for 40 cycles -> req_ready low until busy falls; free_count=32, full=0.
REQ-030 Insert 0xA5 into empty table -> cam_write_enable with addr 0, delete 0; resp OK addr 0; free_count=31.
REQ-031 With CAM_ALLOC_DUP_CHECK_EN, re-insert 0xA5 (CAM returns match addr 0) -> resp DUP addr 0, no cam_write_enable, free_count unchanged.
REQ-032 Insert 32 distinct keys then a 33rd -> 33rd resp FULL, full=1, no CAM write; then delete key at addr 7 -> write delete addr 7, OK; next insert allocates addr 7.
REQ-033 Delete absent key 0x1234 (cam_match=0) -> resp NOTFOUND, no CAM write, free_count unchanged.
REQ-034 Hold cam_write_busy high for 5 cycles in ISSUE -> cam_write_enable held off, then exactly one pulse; assert rst in WAIT -> no resp_valid, free_count=32.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared op/status codes and controller state encoding for the CAM allocation slice.
package cam_pkg;

  typedef enum logic {
    OP_INSERT = 1'b0,
    OP_DELETE = 1'b1
  } cam_op_e;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_FULL     = 2'd1,
    ST_DUP      = 2'd2,
    ST_NOTFOUND = 2'd3
  } cam_status_e;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP_1,
    LOOKUP_2,
    ISSUE,
    WAIT,
    RESP
  } alloc_state_e;

endpackage

// File: rtl/priority_encoder.sv
// LSB-priority encoder: returns the index of the lowest set request bit.
module priority_encoder #(
  parameter int WIDTH     = 32,
  parameter int IDX_WIDTH = 5
) (
  input  logic [WIDTH-1:0]     req,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 found
);

  // Scanning downward lets the lowest set bit win the final assignment.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_WIDTH'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_alloc_ctrl.sv
// CAM entry allocator: owns the valid bitmap, serialises insert/delete requests into CAM writes.
// Optional macro CAM_ALLOC_DUP_CHECK_EN adds a CAM lookup before inserts to reject duplicates.
module cam_alloc_ctrl
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  resp_valid,
  output logic [1:0]            resp_status,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  output logic [DATA_WIDTH-1:0] cam_write_data,
  output logic                  cam_write_delete,
  output logic                  cam_write_enable,
  input  logic                  cam_write_busy,
  output logic [DATA_WIDTH-1:0] cam_compare_data,
  input  logic                  cam_match,
  input  logic [ADDR_WIDTH-1:0] cam_match_addr,
  output logic [ADDR_WIDTH:0]   free_count,
  output logic                  full
);

  localparam int ENTRIES = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ALL_FREE = (ADDR_WIDTH + 1)'(ENTRIES);

  alloc_state_e          state;
  cam_op_e               op_q;
  cam_status_e           resp_status_q;
  logic [DATA_WIDTH-1:0] key_q;
  logic [ENTRIES-1:0]    bitmap;
  logic [ADDR_WIDTH:0]   free_cnt;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [ADDR_WIDTH-1:0] resp_addr_q;
  logic [ADDR_WIDTH-1:0] alloc_idx;
  logic                  alloc_found;
  logic                  wr_del_q;
  logic                  resp_valid_q;
  logic                  ready_en;
  logic                  no_slot;

  priority_encoder #(
    .WIDTH    (ENTRIES),
    .IDX_WIDTH(ADDR_WIDTH)
  ) u_free_pe (
    .req  (~bitmap),
    .idx  (alloc_idx),
    .found(alloc_found)
  );

  assign no_slot          = (free_cnt == '0) || !alloc_found;
  assign req_ready        = ready_en && (state == IDLE) && !cam_write_busy;
  assign cam_write_enable = (state == ISSUE) && !cam_write_busy;
  assign cam_write_addr   = wr_addr_q;
  assign cam_write_data   = key_q;
  assign cam_write_delete = wr_del_q;
  assign cam_compare_data = key_q;
  assign resp_valid       = resp_valid_q;
  assign resp_status      = resp_status_q;
  assign resp_addr        = resp_addr_q;
  assign free_count       = free_cnt;
  assign full             = (free_cnt == '0);

  // ready_en keeps req_ready low while reset is asserted even if the CAM reports idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      op_q          <= OP_INSERT;
      resp_status_q <= ST_OK;
      key_q         <= '0;
      bitmap        <= '0;
      free_cnt      <= ALL_FREE;
      wr_addr_q     <= '0;
      resp_addr_q   <= '0;
      wr_del_q      <= 1'b0;
      resp_valid_q  <= 1'b0;
      ready_en      <= 1'b0;
    end else begin
      ready_en     <= 1'b1;
      resp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            key_q <= req_data;
            op_q  <= cam_op_e'(req_op);
`ifdef CAM_ALLOC_DUP_CHECK_EN
            state <= LOOKUP_1;
`else
            if (req_op == OP_DELETE) begin
              state <= LOOKUP_1;
            end else if (no_slot) begin
              state         <= RESP;
              resp_valid_q  <= 1'b1;
              resp_status_q <= ST_FULL;
              resp_addr_q   <= '0;
            end else begin
              state     <= ISSUE;
              wr_addr_q <= alloc_idx;
              wr_del_q  <= 1'b0;
            end
`endif
          end
        end

        LOOKUP_1: state <= LOOKUP_2;

        // CAM match result is valid here, one cycle after the key was presented.
        LOOKUP_2: begin
          if (op_q == OP_DELETE) begin
            if (cam_match) begin
              state     <= ISSUE;
              wr_addr_q <= cam_match_addr;
              wr_del_q  <= 1'b1;
            end else begin
              state         <= RESP;
              resp_valid_q  <= 1'b1;
              resp_status_q <= ST_NOTFOUND;
              resp_addr_q   <= '0;
            end
          end
`ifdef CAM_ALLOC_DUP_CHECK_EN
          else if (cam_match) begin
            state         <= RESP;
            resp_valid_q  <= 1'b1;
            resp_status_q <= ST_DUP;
            resp_addr_q   <= cam_match_addr;
          end
`endif
          else if (no_slot) begin
            state         <= RESP;
            resp_valid_q  <= 1'b1;
            resp_status_q <= ST_FULL;
            resp_addr_q   <= '0;
          end else begin
            state     <= ISSUE;
            wr_addr_q <= alloc_idx;
            wr_del_q  <= 1'b0;
          end
        end

        // Bookkeeping is guarded by the bit's current value so the counter never drifts.
        ISSUE: begin
          if (!cam_write_busy) begin
            state <= WAIT;
            if (wr_del_q) begin
              if (bitmap[wr_addr_q]) begin
                bitmap[wr_addr_q] <= 1'b0;
                free_cnt          <= free_cnt + 1'b1;
              end
            end else if (!bitmap[wr_addr_q]) begin
              bitmap[wr_addr_q] <= 1'b1;
              free_cnt          <= free_cnt - 1'b1;
            end
          end
        end

        WAIT: begin
          if (!cam_write_busy) begin
            state         <= RESP;
            resp_valid_q  <= 1'b1;
            resp_status_q <= ST_OK;
            resp_addr_q   <= wr_addr_q;
          end
        end

        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_alloc_ctrl.sv
// Self-checking bench for cam_alloc_ctrl; the bench plays the CAM and tracks table contents itself.
module tb_cam_alloc_ctrl;
  import cam_pkg::*;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int N  = 32;
`ifdef CAM_ALLOC_DUP_CHECK_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_op = 1'b0;
  logic [DW-1:0] req_data = '0;
  logic          cam_write_busy = 1'b1;
  logic          cam_match = 1'b0;
  logic [AW-1:0] cam_match_addr = '0;
  logic          req_ready, resp_valid, cam_write_delete, cam_write_enable, full;
  logic [1:0]    resp_status;
  logic [AW-1:0] resp_addr, cam_write_addr;
  logic [DW-1:0] cam_write_data, cam_compare_data;
  logic [AW:0]   free_count;

  int checks = 0;
  int errors = 0;
  int last_wait = 0;

  bit            ref_used[N];
  logic [DW-1:0] ref_key[N];

  always #5 clk = ~clk;

  cam_alloc_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
    .resp_valid(resp_valid), .resp_status(resp_status), .resp_addr(resp_addr),
    .cam_write_addr(cam_write_addr), .cam_write_data(cam_write_data),
    .cam_write_delete(cam_write_delete), .cam_write_enable(cam_write_enable),
    .cam_write_busy(cam_write_busy), .cam_compare_data(cam_compare_data),
    .cam_match(cam_match), .cam_match_addr(cam_match_addr),
    .free_count(free_count), .full(full)
  );

  function automatic int find_key(input logic [DW-1:0] key);
    for (int i = 0; i < N; i++) if (ref_used[i] && ref_key[i] == key) return i;
    return -1;
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < N; i++) if (!ref_used[i]) return i;
    return -1;
  endfunction

  function automatic int used_count();
    int n = 0;
    for (int i = 0; i < N; i++) if (ref_used[i]) n++;
    return n;
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < N; i++) begin
      ref_used[i] = 1'b0;
      ref_key[i]  = '0;
    end
  endfunction

  task automatic apply_reset(input int busy_cycles);
    int ready_seen;
    req_valid      = 1'b0;
    cam_match      = 1'b0;
    cam_write_busy = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || cam_write_enable !== 1'b0 ||
        free_count !== 6'd32 || full !== 1'b0 || cam_write_addr !== '0 ||
        cam_write_delete !== 1'b0 || cam_compare_data !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got ready=%b resp_valid=%b wen=%b free=%0d full=%b waddr=%0d wdel=%b cmp=%h, required 0 0 0 32 0 0 0 0",
               req_ready, resp_valid, cam_write_enable, free_count, full, cam_write_addr,
               cam_write_delete, cam_compare_data);
    end
    clear_model();
    rst = 1'b1;
    ready_seen = 0;
    for (int i = 0; i < busy_cycles; i++) begin
      @(negedge clk);
      if (req_ready !== 1'b0) ready_seen++;
    end
    checks++;
    if (ready_seen != 0) begin
      errors++;
      $display("[TB] FAIL ready_during_init: req_ready high in %0d cycles, required 0", ready_seen);
    end
    checks++;
    if (free_count !== 6'd32 || full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL status_after_release: free=%0d full=%b, required 32 0", free_count, full);
    end
    cam_write_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_init: req_ready=%b, required 1", req_ready);
    end
  endtask

  task automatic do_req(input logic op, input logic [DW-1:0] key, input int stall, input string tag);
    int hit, slot, exp_st, exp_addr, exp_lat, issue_cyc, busy_until, stl, waited;
    int wr_cnt, wr_cyc, lat;
    logic [AW-1:0] wr_addr, got_addr;
    logic          wr_del;
    logic [DW-1:0] wr_data;
    logic [1:0]    got_st;
    bit            got, cmp_ok;
    hit = find_key(key);
    slot = lowest_free();
    stl = stall;
    issue_cyc = -1;
    exp_addr = 0;
    if (op == OP_DELETE) begin
      if (hit < 0) begin exp_st = ST_NOTFOUND; exp_lat = 3; end
      else begin exp_st = ST_OK; exp_addr = hit; exp_lat = 5; issue_cyc = 3; end
    end else if (DUP_EN && hit >= 0) begin
      exp_st = ST_DUP; exp_addr = hit; exp_lat = 3;
    end else if (slot < 0) begin
      exp_st = ST_FULL; exp_lat = DUP_EN ? 3 : 1;
    end else begin
      exp_st = ST_OK; exp_addr = slot;
      exp_lat = DUP_EN ? 5 : 3; issue_cyc = DUP_EN ? 3 : 1;
    end
    if (issue_cyc < 0) stl = 0;
    busy_until = (stl > 0) ? issue_cyc + stl - 1 : 0;
    exp_lat += stl;

    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (req_ready !== 1'b1 && waited < 200);
    last_wait = waited;
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s ready_timeout: req_ready=%b after %0d cycles, required 1", tag, req_ready, waited);
      return;
    end
    req_valid      = 1'b1;
    req_op         = op;
    req_data       = key;
    cam_match      = (hit >= 0);
    cam_match_addr = (hit >= 0) ? AW'(hit) : '0;
    @(posedge clk);

    wr_cnt = 0; wr_cyc = 0; lat = 0; got = 1'b0; cmp_ok = 1'b0;
    wr_addr = '0; wr_del = 1'b0; wr_data = '0; got_st = '0; got_addr = '0;
    for (int c = 1; c <= 80 && !got; c++) begin
      #1;
      req_valid      = 1'b0;
      cam_write_busy = (c <= busy_until);
      @(negedge clk);
      if (cam_write_enable === 1'b1) begin
        wr_cnt++;
        wr_cyc  = c;
        wr_addr = cam_write_addr;
        wr_del  = cam_write_delete;
        wr_data = cam_write_data;
      end
      if (resp_valid === 1'b1) begin
        got      = 1'b1;
        lat      = c;
        got_st   = resp_status;
        got_addr = resp_addr;
        cmp_ok   = (cam_compare_data === key);
      end else begin
        @(posedge clk);
      end
    end
    cam_match      = 1'b0;
    cam_write_busy = 1'b0;

    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL %s resp_timeout: no resp_valid in 80 cycles, required one", tag);
    end else begin
      checks++;
      if (got_st !== 2'(exp_st)) begin
        errors++;
        $display("[TB] FAIL %s status: got %0d, required %0d", tag, got_st, exp_st);
      end
      if (exp_st == ST_OK || exp_st == ST_DUP) begin
        checks++;
        if (got_addr !== AW'(exp_addr)) begin
          errors++;
          $display("[TB] FAIL %s resp_addr: got %0d, required %0d", tag, got_addr, exp_addr);
        end
      end
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("[TB] FAIL %s latency: got %0d, required %0d", tag, lat, exp_lat);
      end
      checks++;
      if (!cmp_ok) begin
        errors++;
        $display("[TB] FAIL %s compare_data: got %h, required %h", tag, cam_compare_data, key);
      end
    end
    checks++;
    if (wr_cnt != ((issue_cyc > 0) ? 1 : 0)) begin
      errors++;
      $display("[TB] FAIL %s write_count: got %0d, required %0d", tag, wr_cnt, (issue_cyc > 0) ? 1 : 0);
    end
    if (issue_cyc > 0 && wr_cnt == 1) begin
      checks++;
      if (wr_addr !== AW'(exp_addr) || wr_del !== op || wr_data !== key || wr_cyc != issue_cyc + stl) begin
        errors++;
        $display("[TB] FAIL %s write_fields: got addr=%0d del=%b data=%h cycle=%0d, required %0d %b %h %0d",
                 tag, wr_addr, wr_del, wr_data, wr_cyc, exp_addr, op, key, issue_cyc + stl);
      end
    end

    if (exp_st == ST_OK) begin
      if (op == OP_DELETE) ref_used[hit] = 1'b0;
      else begin
        ref_used[slot] = 1'b1;
        ref_key[slot]  = key;
      end
    end
    checks++;
    if (free_count !== 6'(N - used_count()) || full !== (used_count() == N)) begin
      errors++;
      $display("[TB] FAIL %s free_status: got free=%0d full=%b, required %0d %b",
               tag, free_count, full, N - used_count(), used_count() == N);
    end
  endtask

  task automatic test_reset();
    apply_reset(40);
  endtask

  task automatic test_insert_basic();
    do_req(OP_INSERT, 64'hA5, 0, "insert_a5");
    checks++;
    if (free_count !== 6'd31) begin
      errors++;
      $display("[TB] FAIL insert_a5_count: got %0d, required 31", free_count);
    end
  endtask

  task automatic test_dup();
    do_req(OP_INSERT, 64'hA5, 0, "dup_a5");
  endtask

  task automatic test_notfound();
    do_req(OP_DELETE, 64'h1234, 0, "delete_absent");
  endtask

  task automatic test_full();
    apply_reset(4);
    for (int i = 0; i < N; i++) do_req(OP_INSERT, 64'h100 + 64'(i), 0, "fill");
    do_req(OP_INSERT, 64'h200, 0, "insert_when_full");
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_flag: got %b, required 1", full);
    end
    do_req(OP_DELETE, 64'h107, 0, "delete_addr7");
    do_req(OP_INSERT, 64'h300, 0, "reuse_addr7");
    checks++;
    if (resp_addr !== 5'd7) begin
      errors++;
      $display("[TB] FAIL reuse_addr7_const: got %0d, required 7", resp_addr);
    end
  endtask

  task automatic test_busy_stall();
    apply_reset(4);
    do_req(OP_INSERT, 64'h55, 5, "busy_stall");
  endtask

  task automatic test_reset_in_wait();
    int waited, bad;
    bit seen;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (req_ready !== 1'b1 && waited < 200);
    req_valid = 1'b1;
    req_op    = OP_INSERT;
    req_data  = 64'h77;
    cam_match = 1'b0;
    @(posedge clk);
    seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      if (cam_write_enable === 1'b1) seen = 1'b1;
      else @(posedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL wait_reset_issue: cam_write_enable never seen, required one pulse");
    end
    @(posedge clk);
    #1 cam_write_busy = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL wait_reset_resp: resp_valid high %0d cycles, required 0", bad);
    end
    checks++;
    if (free_count !== 6'd32 || full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wait_reset_count: got free=%0d full=%b, required 32 0", free_count, full);
    end
    apply_reset(3);
  endtask

  task automatic test_back_to_back();
    do_req(OP_INSERT, 64'hB0, 0, "b2b_first");
    do_req(OP_INSERT, 64'hB1, 0, "b2b_second");
    checks++;
    if (last_wait != 1) begin
      errors++;
      $display("[TB] FAIL b2b_ready: waited %0d cycles after resp, required 1", last_wait);
    end
    do_req(OP_DELETE, 64'hB0, 0, "b2b_delete");
  endtask

  task automatic test_random();
    logic          op;
    logic [DW-1:0] key;
    int            stall;
    apply_reset(2);
    for (int i = 0; i < 150; i++) begin
      op    = ($urandom_range(0, 2) == 0) ? OP_DELETE : OP_INSERT;
      key   = 64'h1000 + 64'($urandom_range(0, 39));
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_req(op, key, stall, "random");
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_insert_basic();
`ifdef CAM_ALLOC_DUP_CHECK_EN
    test_dup();
`endif
    test_notfound();
    test_back_to_back();
    test_full();
    test_busy_stall();
    test_reset_in_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
